// File: rtl/data_memory.sv
// Byte-addressable data memory with load/store formatting and a read-only MMIO counter block.
// Loads are combinational; stores and counters update on the rising clock edge.
module data_memory #(
    parameter int         DEPTH_WORDS = 256,
    parameter logic [3:0] MMIO_NIBBLE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        AccessFault,
    output logic        FaultSticky
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [63:0]      cycle_count_q, cycle_count_d;
    logic [31:0]      store_count_q, store_count_d;
    logic             fault_sticky_q, fault_sticky_d;

    logic             is_mmio;
    logic [IDX_W-1:0] word_idx;
    logic             illegal_f3;
    logic             misaligned;
    logic             store_commit;
    logic [3:0]       byte_en;
    logic [31:0]      store_word;
    logic [31:0]      mmio_word;
    logic [31:0]      raw_word;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;

    always_comb begin
        is_mmio    = (Address[31:28] == MMIO_NIBBLE);
        word_idx   = Address[IDX_W+1:2];
        illegal_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        misaligned = ((funct3[1:0] == 2'b01) && Address[0]) ||
                     ((funct3[1:0] == 2'b10) && (Address[1:0] != 2'b00));
        // The unsigned load encodings have no store counterpart.
        AccessFault = (MemRead || MemWrite) &&
                      (illegal_f3 || misaligned || (MemWrite && funct3[2]));
    end

    always_comb begin
        case (Address[27:2])
            26'd0:   mmio_word = cycle_count_q[31:0];
            26'd1:   mmio_word = cycle_count_q[63:32];
            26'd2:   mmio_word = store_count_q;
            default: mmio_word = 32'h0;
        endcase
        raw_word = is_mmio ? mmio_word : mem_q[word_idx];
        sel_byte = raw_word[{Address[1:0], 3'b000} +: 8];
        sel_half = Address[1] ? raw_word[31:16] : raw_word[15:0];

        ReadData = 32'h0;
        if (!(illegal_f3 || misaligned || AccessFault)) begin
            case (funct3)
                3'b000:  ReadData = {{24{sel_byte[7]}}, sel_byte};
                3'b100:  ReadData = {24'h0, sel_byte};
                3'b001:  ReadData = {{16{sel_half[15]}}, sel_half};
                3'b101:  ReadData = {16'h0, sel_half};
                3'b010:  ReadData = raw_word;
                default: ReadData = 32'h0;
            endcase
        end
    end

    always_comb begin
        store_commit = MemWrite && !AccessFault && !is_mmio && !rst;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << Address[1:0];
                store_word = {4{WriteData[7:0]}};
            end
            2'b01: begin
                byte_en    = Address[1] ? 4'b1100 : 4'b0011;
                store_word = {2{WriteData[15:0]}};
            end
            2'b10: begin
                byte_en    = 4'b1111;
                store_word = WriteData;
            end
            default: begin
                byte_en    = 4'b0000;
                store_word = WriteData;
            end
        endcase
        cycle_count_d  = cycle_count_q + 64'd1;
        store_count_d  = store_count_q + {31'h0, store_commit};
        fault_sticky_d = fault_sticky_q | AccessFault;
    end

    // RAM is deliberately left out of reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (store_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem_q[word_idx][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count_q  <= 64'h0;
            store_count_q  <= 32'h0;
            fault_sticky_q <= 1'b0;
        end else begin
            cycle_count_q  <= cycle_count_d;
            store_count_q  <= store_count_d;
            fault_sticky_q <= fault_sticky_d;
        end
    end

    assign FaultSticky = fault_sticky_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: a byte-array reference model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        AccessFault;
    logic        FaultSticky;

    int checks = 0;
    int errors = 0;
    bit force_pending = 1'b0;

    logic [7:0]  m_bytes [1024] = '{default: 8'h00};
    logic [63:0] m_cycle = 64'h0;
    logic [31:0] m_stores = 32'h0;
    logic        m_sticky = 1'b0;

    always #5 clk = ~clk;

    data_memory #(.DEPTH_WORDS(256), .MMIO_NIBBLE(4'hF)) dut (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .MemRead(MemRead),
        .funct3(funct3), .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .AccessFault(AccessFault), .FaultSticky(FaultSticky)
    );

    function automatic bit m_fault(input logic [31:0] a, input logic [2:0] f, input bit mr, input bit mw);
        if (!(mr || mw)) return 1'b0;
        if (f == 3 || f == 6 || f == 7) return 1'b1;
        if (mw && (f == 4 || f == 5)) return 1'b1;
        if ((f == 1 || f == 5) && (a % 2 != 0)) return 1'b1;
        if (f == 2 && (a % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        int base;
        if (a[31:28] == 4'hF) begin
            case (a[27:0] / 4)
                0: return m_cycle[31:0];
                1: return m_cycle[63:32];
                2: return m_stores;
                default: return 32'h0;
            endcase
        end
        base = int'(a % 1024) / 4 * 4;
        return {m_bytes[base+3], m_bytes[base+2], m_bytes[base+1], m_bytes[base]};
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [2:0] f, input bit mr, input bit mw);
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        if (m_fault(a, f, 1'b1, 1'b0) || m_fault(a, f, mr, mw)) return 32'h0;
        w = m_word(a);
        b = (w >> ((a % 4) * 8)) & 32'hFF;
        h = (w >> ((a % 4) * 8)) & 32'hFFFF;
        case (f)
            3'd0: return (b >= 128) ? b - 256 : b;
            3'd4: return b;
            3'd1: return (h >= 32768) ? h - 65536 : h;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cycle  <= 64'h0;
            m_stores <= 32'h0;
            m_sticky <= 1'b0;
        end else begin
            if (m_fault(Address, funct3, MemRead, MemWrite)) m_sticky <= 1'b1;
            if (MemWrite && !m_fault(Address, funct3, MemRead, MemWrite) && Address[31:28] != 4'hF) begin
                for (int i = 0; i < (1 << funct3[1:0]); i++) begin
                    m_bytes[(int'(Address % 1024) + i) % 1024] <= WriteData[8*i +: 8];
                end
                m_stores <= m_stores + 32'd1;
            end
            m_cycle <= force_pending ? 64'h0 : m_cycle + 64'd1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit mr, input bit mw, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        MemRead = mr;
        MemWrite = mw;
        funct3 = f;
        Address = a;
        WriteData = wd;
        @(negedge clk);
        checkOutput("model_ReadData", ReadData, m_read(a, f, mr, mw));
        checkOutput("model_AccessFault", {31'h0, AccessFault}, {31'h0, m_fault(a, f, mr, mw)});
        checkOutput("model_FaultSticky", {31'h0, FaultSticky}, {31'h0, m_sticky});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        MemRead = 1'b1;
        funct3 = 3'b010;
        Address = 32'hF000_0000;
        #1;
        checkOutput("reset_cycle_lo", ReadData, 32'h0);
        checkOutput("reset_sticky", {31'h0, FaultSticky}, 32'h0);
        #1 rst = 1'b0;

        applyStimulus(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        applyStimulus(1, 0, 3'b010, 32'h10, 32'h0);
        checkOutput("lw_0x10", ReadData, 32'hDEAD_BEEF);
        applyStimulus(1, 0, 3'b010, 32'hF000_0008, 32'h0);
        checkOutput("store_count_1", ReadData, 32'd1);

        applyStimulus(0, 1, 3'b010, 32'h20, 32'h0);
        applyStimulus(0, 1, 3'b000, 32'h21, 32'hFFFF_FF80);
        applyStimulus(1, 0, 3'b010, 32'h20, 32'h0);
        checkOutput("lw_0x20_after_sb", ReadData, 32'h0000_8000);
        applyStimulus(1, 0, 3'b000, 32'h21, 32'h0);
        checkOutput("lb_0x21", ReadData, 32'hFFFF_FF80);
        applyStimulus(1, 0, 3'b100, 32'h21, 32'h0);
        checkOutput("lbu_0x21", ReadData, 32'h0000_0080);

        applyStimulus(0, 1, 3'b001, 32'h32, 32'hABCD_1234);
        applyStimulus(1, 0, 3'b001, 32'h32, 32'h0);
        checkOutput("lh_0x32", ReadData, 32'h0000_1234);
        applyStimulus(1, 0, 3'b101, 32'h30, 32'h0);
        checkOutput("lhu_0x30", ReadData, 32'h0);

        applyStimulus(1, 0, 3'b010, 32'h13, 32'h0);
        checkOutput("lw_misaligned_fault", {31'h0, AccessFault}, 32'd1);
        checkOutput("lw_misaligned_data", ReadData, 32'h0);
        applyStimulus(0, 0, 3'b000, 32'h0, 32'h0);
        checkOutput("sticky_set", {31'h0, FaultSticky}, 32'd1);

        applyStimulus(0, 1, 3'b010, 32'h11, 32'h0000_0055);
        checkOutput("sw_misaligned_fault", {31'h0, AccessFault}, 32'd1);
        applyStimulus(0, 1, 3'b011, 32'h10, 32'h1111_1111);
        checkOutput("sw_bad_f3_fault", {31'h0, AccessFault}, 32'd1);
        applyStimulus(0, 1, 3'b010, 32'hF000_0008, 32'h0000_0099);
        applyStimulus(1, 0, 3'b010, 32'h10, 32'h0);
        checkOutput("lw_0x10_unchanged", ReadData, 32'hDEAD_BEEF);
        applyStimulus(1, 0, 3'b010, 32'hF000_0008, 32'h0);
        checkOutput("store_count_4", ReadData, 32'd4);

        applyStimulus(0, 1, 3'b010, 32'h400, 32'hCAFE_F00D);
        applyStimulus(1, 0, 3'b010, 32'h0, 32'h0);
        checkOutput("alias_0x400", ReadData, 32'hCAFE_F00D);

        applyStimulus(1, 1, 3'b010, 32'h40, 32'hA5A5_A5A5);
        checkOutput("rw_old_data", ReadData, 32'h0);
        applyStimulus(1, 0, 3'b010, 32'h40, 32'h0);
        checkOutput("rw_new_data", ReadData, 32'hA5A5_A5A5);
        applyStimulus(1, 0, 3'b010, 32'hF000_0000, 32'h0);

        applyStimulus(1, 0, 3'b010, 32'hF000_0004, 32'h0);
        #1 force dut.cycle_count_q = 64'hFFFF_FFFF_FFFF_FFFF;
        force_pending = 1'b1;
        #1 release dut.cycle_count_q;
        #1 checkOutput("cycle_hi_forced", ReadData, 32'hFFFF_FFFF);
        applyStimulus(1, 0, 3'b010, 32'hF000_0000, 32'h0);
        force_pending = 1'b0;
        checkOutput("cycle_lo_wrapped", ReadData, 32'h0);
        applyStimulus(1, 0, 3'b010, 32'hF000_0004, 32'h0);
        checkOutput("cycle_hi_wrapped", ReadData, 32'h0);

        applyStimulus(1, 0, 3'b010, 32'hF000_0008, 32'h0);
        #1 rst = 1'b1;
        Address = 32'hF000_0008;
        #1;
        checkOutput("async_store_count", ReadData, 32'h0);
        checkOutput("async_sticky", {31'h0, FaultSticky}, 32'h0);
        Address = 32'h10;
        #1 checkOutput("async_ram_kept", ReadData, 32'hDEAD_BEEF);
        rst = 1'b0;
        applyStimulus(1, 0, 3'b010, 32'h10, 32'h0);
        checkOutput("post_reset_lw", ReadData, 32'hDEAD_BEEF);
        applyStimulus(1, 0, 3'b010, 32'hF000_0000, 32'h0);
        checkOutput("post_reset_cycle", ReadData, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
